llsc_ctrl: RTL and testbench
============================

Name: llsc_ctrl

Overview:
- Reservation controller for LL.W/SC.W in the dual-issue commit stage.
- Owns the LLbit and the reserved physical address.
- Sequences updates from both commit slots, exception flush, ERTN, LLBCTL CSR writes and store snoops.
- Produces the SC success result for the writeback of each slot.

Parameters:
ADDR_WIDTH, 32, physical address width of reservation and compare
GRAN_BITS, 4, low address bits ignored in compare (16-byte reservation granule)
TIMEOUT, 1024, cycles before a reservation self-expires (only with LLSC_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  exception flush; squashes both slots this cycle
ertn  in  1  ERTN commits this cycle
slot0_valid  in  1  slot 0 (older) commits a memory op
slot0_op  in  2  0 NONE, 1 LL, 2 SC, 3 reserved (treated as NONE)
slot0_addr  in  ADDR_WIDTH  physical address of slot 0 op
slot1_valid  in  1  slot 1 (younger) commits a memory op
slot1_op  in  2  encoding as slot0_op
slot1_addr  in  ADDR_WIDTH  physical address of slot 1 op
snoop_valid  in  1  store by another agent observed
snoop_addr  in  ADDR_WIDTH  snooped store address
wcllb  in  1  LLBCTL.WCLLB write of 1 (clear LLbit)
klo_we  in  1  LLBCTL.KLO write strobe
klo_wdata  in  1  LLBCTL.KLO write data
sc0_success  out  1  slot 0 SC result (combinational)
sc1_success  out  1  slot 1 SC result (combinational)
llbit_o  out  1  registered LLbit
klo_o  out  1  registered KLO
resv_addr_o  out  ADDR_WIDTH  registered reservation address

Behaviour:
- Reset values (asynchronous): llbit_o=0, klo_o=0, resv_addr_o=0, timeout counter=0.
- State machine: IDLE (llbit_o=0) and RESERVED (llbit_o=1). All updates take effect at the next posedge.
- Granule match: addr[ADDR_WIDTH-1:GRAN_BITS] == resv_addr_o[ADDR_WIDTH-1:GRAN_BITS].
- Snoop hit: snoop_valid && RESERVED && snoop_addr matches the granule (compare uses the registered state).
- Per-cycle evaluation, in this order:
  1. flush=1: both slots ignored; sc0/sc1_success=0; next state IDLE. ertn, snoop and wcllb are irrelevant. klo_we still applies.
  2. Slot 0, then slot 1, sequentially; slot 1 sees the state left by slot 0.
     - LL: state RESERVED, resv_addr = slot addr.
     - SC: success = current(post-older) RESERVED && granule match && !snoop hit. After any SC the state is IDLE, success or not.
     - A slot 0 LL followed by a slot 1 SC to the same granule succeeds.
     - A slot 0 SC followed by a slot 1 SC: slot 1 fails.
  3. Snoop hit clears the reservation. Exception: a slot LL in the same cycle establishes a new reservation, which wins.
  4. wcllb clears the state after slot processing.
  5. ertn with klo_o=0: clear. ertn with klo_o=1: keep the state and set klo<=0.
  6. klo_we: klo <= klo_wdata. This overrides the ertn self-clear in the same cycle.
- sc*_success is 0 whenever the slot is not valid, its op is not SC, or flush=1.
- Mid-operation reset returns to IDLE immediately, with no wait for a clock.
- Two LLs in one cycle: the slot 1 address is kept.

Optional Feature:
- Macro: LLSC_TIMEOUT_EN.
- Defined: a counter clears to 0 on every LL and increments each cycle while RESERVED. When it reaches TIMEOUT-1 and no LL arrives that cycle, the next state is IDLE. This guarantees forward progress for spin loops.
- Undefined: no counter is present, and a reservation persists until an explicit clear event.

Decomposition:
- Shared package (existing core defines package) holds:
  - the memory-op encoding enum (MEM_NONE, MEM_LL, MEM_SC)
  - the default ADDR_WIDTH constant
  - the LLBCTL field bit positions
- The sequential slot evaluation lives in one function or combinational sub-module, llsc_slot_eval, instantiated twice in a chain.
- Timeout counter stays inline.

Test Plan:
- LL slot0 addr 0x1000, next cycle SC slot0 addr 0x100C -> sc0_success=1, then llbit_o=0, resv_addr_o=0x1000.
- LL slot0 0x2000, snoop 0x2008 the cycle before the SC to 0x2000 -> sc0_success=0. The same snoop in the SC's own cycle also -> sc0_success=0.
- Same cycle: slot0 LL 0x3000, slot1 SC 0x3004 -> sc1_success=1, llbit_o=0 next cycle. Same cycle: slot0 SC, slot1 SC while RESERVED -> sc0_success=1, sc1_success=0.
- RESERVED, flush with slot1 SC valid -> sc1_success=0, llbit_o=0. RESERVED, klo=1, ertn -> llbit_o stays 1, klo_o=0. A second ertn -> llbit_o=0.
- LL 0x4000 then rst_n low for a half-cycle -> llbit_o=0 before the next edge. wcllb while RESERVED -> llbit_o=0.
- LLSC_TIMEOUT_EN with TIMEOUT=8: LL at cycle 0, no further ops -> llbit_o=1 through cycle 8, 0 from cycle 9. With an LL at cycle 5 the counter restarts, and llbit_o falls at cycle 14.

Source files
------------

// File: rtl/llsc_ctrl_pkg.sv
// LL/SC reservation controller shared definitions.
// Memory-op encoding, state encoding and LLBCTL field positions.
package llsc_ctrl_pkg;

    localparam int LLSC_ADDR_WIDTH = 32;

    localparam int LLBCTL_ROLLB = 0;
    localparam int LLBCTL_WCLLB = 1;
    localparam int LLBCTL_KLO   = 2;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LL   = 2'd1,
        MEM_SC   = 2'd2
    } mem_op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        RESERVED = 1'b1
    } llsc_state_e;

endpackage

// File: rtl/llsc_slot_eval.sv
// One commit slot's effect on the LL/SC reservation.
// Chained so the younger slot sees the older slot's result.
module llsc_slot_eval
    import llsc_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = LLSC_ADDR_WIDTH,
    parameter int GRAN_BITS  = 4
) (
    input  logic                  valid,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  in_resv,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  snoop_hit,
    output logic                  out_resv,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  sc_success,
    output logic                  is_ll
);

    localparam logic [ADDR_WIDTH-1:0] GRAN_MASK =
        {ADDR_WIDTH{1'b1}} << GRAN_BITS;

    logic match;

    assign match = ((addr ^ in_addr) & GRAN_MASK) == '0;

    always_comb begin
        out_resv   = in_resv;
        out_addr   = in_addr;
        sc_success = 1'b0;
        is_ll      = 1'b0;
        if (valid) begin
            case (op)
                MEM_LL: begin
                    out_resv = 1'b1;
                    out_addr = addr;
                    is_ll    = 1'b1;
                end
                MEM_SC: begin
                    sc_success = in_resv && match && !snoop_hit;
                    out_resv   = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/llsc_ctrl.sv
// LLbit / reservation controller for the dual-issue commit stage.
// Optional self-expiring reservation under LLSC_TIMEOUT_EN.
module llsc_ctrl
    import llsc_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = LLSC_ADDR_WIDTH,
    parameter int GRAN_BITS  = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  ertn,
    input  logic                  slot0_valid,
    input  logic [1:0]            slot0_op,
    input  logic [ADDR_WIDTH-1:0] slot0_addr,
    input  logic                  slot1_valid,
    input  logic [1:0]            slot1_op,
    input  logic [ADDR_WIDTH-1:0] slot1_addr,
    input  logic                  snoop_valid,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    input  logic                  wcllb,
    input  logic                  klo_we,
    input  logic                  klo_wdata,
    output logic                  sc0_success,
    output logic                  sc1_success,
    output logic                  llbit_o,
    output logic                  klo_o,
    output logic [ADDR_WIDTH-1:0] resv_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] GRAN_MASK =
        {ADDR_WIDTH{1'b1}} << GRAN_BITS;

    llsc_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] resv_addr_q, resv_addr_d;
    logic                  klo_q, klo_d;
    logic                  snoop_hit, any_ll, expire;
    logic                  resv0, resv1, ll0, ll1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;

    assign snoop_hit = snoop_valid && (state_q == RESERVED) &&
        (((snoop_addr ^ resv_addr_q) & GRAN_MASK) == '0);

    llsc_slot_eval #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .GRAN_BITS  (GRAN_BITS)
    ) u_slot0 (
        .valid      (slot0_valid && !flush),
        .op         (slot0_op),
        .addr       (slot0_addr),
        .in_resv    (state_q == RESERVED),
        .in_addr    (resv_addr_q),
        .snoop_hit  (snoop_hit),
        .out_resv   (resv0),
        .out_addr   (addr0),
        .sc_success (sc0_success),
        .is_ll      (ll0)
    );

    llsc_slot_eval #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .GRAN_BITS  (GRAN_BITS)
    ) u_slot1 (
        .valid      (slot1_valid && !flush),
        .op         (slot1_op),
        .addr       (slot1_addr),
        .in_resv    (resv0),
        .in_addr    (addr0),
        .snoop_hit  (snoop_hit),
        .out_resv   (resv1),
        .out_addr   (addr1),
        .sc_success (sc1_success),
        .is_ll      (ll1)
    );

    assign any_ll = ll0 || ll1;

`ifdef LLSC_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] tmo_q;

    assign expire = (state_q == RESERVED) && !any_ll &&
        (tmo_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (any_ll || expire || state_q != RESERVED) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d     = resv1 ? RESERVED : IDLE;
        resv_addr_d = addr1;
        klo_d       = klo_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            // A same-cycle LL re-arms the reservation despite the snoop
            if (snoop_hit && !any_ll) state_d = IDLE;
            if (wcllb) state_d = IDLE;
            if (ertn) begin
                if (klo_q) klo_d = 1'b0;
                else state_d = IDLE;
            end
            if (expire) state_d = IDLE;
        end
        if (klo_we) klo_d = klo_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            resv_addr_q <= '0;
            klo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            resv_addr_q <= resv_addr_d;
            klo_q       <= klo_d;
        end
    end

    assign llbit_o     = (state_q == RESERVED);
    assign klo_o       = klo_q;
    assign resv_addr_o = resv_addr_q;

endmodule

// File: tb/tb_llsc_ctrl.sv
// Scoreboard bench for llsc_ctrl: SC results and registered state per cycle.
module tb_llsc_ctrl;
    import llsc_ctrl_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, ertn;
    logic          slot0_valid, slot1_valid;
    logic [1:0]    slot0_op, slot1_op;
    logic [AW-1:0] slot0_addr, slot1_addr;
    logic          snoop_valid;
    logic [AW-1:0] snoop_addr;
    logic          wcllb, klo_we, klo_wdata;
    logic          sc0_success, sc1_success, llbit_o, klo_o;
    logic [AW-1:0] resv_addr_o;

    logic [AW+3:0] sb[$];
    logic [AW+3:0] obs, e;
    logic          o_sc0, o_sc1;
    int            checks = 0;
    int            errors = 0;

    llsc_ctrl #(
        .ADDR_WIDTH (AW),
        .GRAN_BITS  (4),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .ertn        (ertn),
        .slot0_valid (slot0_valid),
        .slot0_op    (slot0_op),
        .slot0_addr  (slot0_addr),
        .slot1_valid (slot1_valid),
        .slot1_op    (slot1_op),
        .slot1_addr  (slot1_addr),
        .snoop_valid (snoop_valid),
        .snoop_addr  (snoop_addr),
        .wcllb       (wcllb),
        .klo_we      (klo_we),
        .klo_wdata   (klo_wdata),
        .sc0_success (sc0_success),
        .sc1_success (sc1_success),
        .llbit_o     (llbit_o),
        .klo_o       (klo_o),
        .resv_addr_o (resv_addr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [AW+3:0] mk(input logic s0, input logic s1,
                                         input logic ll, input logic k,
                                         input logic [AW-1:0] a);
        return {s0, s1, ll, k, a};
    endfunction

    task automatic clr();
        flush = 0; ertn = 0;
        slot0_valid = 0; slot0_op = MEM_NONE; slot0_addr = '0;
        slot1_valid = 0; slot1_op = MEM_NONE; slot1_addr = '0;
        snoop_valid = 0; snoop_addr = '0;
        wcllb = 0; klo_we = 0; klo_wdata = 0;
    endtask

    task automatic s0(input logic [1:0] op, input logic [AW-1:0] a);
        slot0_valid = 1; slot0_op = op; slot0_addr = a;
    endtask

    task automatic s1(input logic [1:0] op, input logic [AW-1:0] a);
        slot1_valid = 1; slot1_op = op; slot1_addr = a;
    endtask

    task automatic snoop(input logic [AW-1:0] a);
        snoop_valid = 1; snoop_addr = a;
    endtask

    // Inputs already driven; sample SC at negedge, state after posedge.
    task automatic cycle();
        @(negedge clk);
        o_sc0 = sc0_success;
        o_sc1 = sc1_success;
        @(posedge clk);
        #1;
        obs = {o_sc0, o_sc1, llbit_o, klo_o, resv_addr_o};
        clr();
    endtask

    task automatic test_reset();
        clr();
        rst_n = 0;
        s0(MEM_SC, 32'h0);
        #2;
        sb.push_back(mk(0, 0, 0, 0, 32'h0));
        obs = {sc0_success, sc1_success, llbit_o, klo_o, resv_addr_o};
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset got %h exp %h", obs, e);
        end
        #5 rst_n = 1;
        clr();
        @(posedge clk);
        #1;
    endtask

    task automatic test_ll_sc();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin s0(MEM_LL, 32'h1000); sb.push_back(mk(0, 0, 1, 0, 32'h1000)); end
                1: begin s0(MEM_SC, 32'h100C); sb.push_back(mk(1, 0, 0, 0, 32'h1000)); end
                default: begin s0(MEM_SC, 32'h1000); sb.push_back(mk(0, 0, 0, 0, 32'h1000)); end
            endcase
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ll_sc c%0d got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_snoop();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin s0(MEM_LL, 32'h2000); sb.push_back(mk(0, 0, 1, 0, 32'h2000)); end
                1: begin snoop(32'h2008); sb.push_back(mk(0, 0, 0, 0, 32'h2000)); end
                2: begin s0(MEM_SC, 32'h2000); sb.push_back(mk(0, 0, 0, 0, 32'h2000)); end
                3: begin s0(MEM_LL, 32'h2000); sb.push_back(mk(0, 0, 1, 0, 32'h2000)); end
                4: begin
                    s0(MEM_SC, 32'h2000); snoop(32'h2008);
                    sb.push_back(mk(0, 0, 0, 0, 32'h2000));
                end
                5: begin s0(MEM_LL, 32'h2000); sb.push_back(mk(0, 0, 1, 0, 32'h2000)); end
                6: begin
                    s0(MEM_LL, 32'h2100); snoop(32'h2000);
                    sb.push_back(mk(0, 0, 1, 0, 32'h2100));
                end
                7: begin snoop(32'h3000); sb.push_back(mk(0, 0, 1, 0, 32'h2100)); end
                default: begin s0(MEM_SC, 32'h2104); sb.push_back(mk(1, 0, 0, 0, 32'h2100)); end
            endcase
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL snoop c%0d got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_dual_slot();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin
                    s0(MEM_LL, 32'h3000); s1(MEM_SC, 32'h3004);
                    sb.push_back(mk(0, 1, 0, 0, 32'h3000));
                end
                1: begin s0(MEM_LL, 32'h5000); sb.push_back(mk(0, 0, 1, 0, 32'h5000)); end
                2: begin
                    s0(MEM_SC, 32'h5000); s1(MEM_SC, 32'h5000);
                    sb.push_back(mk(1, 0, 0, 0, 32'h5000));
                end
                3: begin
                    s0(MEM_LL, 32'h6000); s1(MEM_LL, 32'h7010);
                    sb.push_back(mk(0, 0, 1, 0, 32'h7010));
                end
                4: begin
                    s0(MEM_SC, 32'h6000); s1(MEM_SC, 32'h7010);
                    sb.push_back(mk(0, 0, 0, 0, 32'h7010));
                end
                5: begin
                    s0(2'd3, 32'h8000);
                    slot1_op = MEM_LL; slot1_addr = 32'h9000;
                    sb.push_back(mk(0, 0, 0, 0, 32'h7010));
                end
                default: begin
                    s0(MEM_LL, 32'hA000); s1(2'd3, 32'hB000);
                    sb.push_back(mk(0, 0, 1, 0, 32'hA000));
                end
            endcase
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL dual c%0d got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_flush_ertn();
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin
                    flush = 1; s0(MEM_LL, 32'hB000); s1(MEM_SC, 32'hA000);
                    sb.push_back(mk(0, 0, 0, 0, 32'hA000));
                end
                1: begin
                    s0(MEM_LL, 32'hA000); klo_we = 1; klo_wdata = 1;
                    sb.push_back(mk(0, 0, 1, 1, 32'hA000));
                end
                2: begin ertn = 1; sb.push_back(mk(0, 0, 1, 0, 32'hA000)); end
                3: begin ertn = 1; sb.push_back(mk(0, 0, 0, 0, 32'hA000)); end
                4: begin
                    s0(MEM_LL, 32'hC000); klo_we = 1; klo_wdata = 1;
                    sb.push_back(mk(0, 0, 1, 1, 32'hC000));
                end
                5: begin
                    ertn = 1; klo_we = 1; klo_wdata = 1;
                    sb.push_back(mk(0, 0, 1, 1, 32'hC000));
                end
                6: begin
                    flush = 1; klo_we = 1; klo_wdata = 0;
                    sb.push_back(mk(0, 0, 0, 0, 32'hC000));
                end
                7: begin s0(MEM_LL, 32'hC000); sb.push_back(mk(0, 0, 1, 0, 32'hC000)); end
                8: begin wcllb = 1; sb.push_back(mk(0, 0, 0, 0, 32'hC000)); end
                default: begin
                    s0(MEM_LL, 32'hD000); wcllb = 1;
                    sb.push_back(mk(0, 0, 0, 0, 32'hD000));
                end
            endcase
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL flush_ertn c%0d got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        s0(MEM_LL, 32'h4000); klo_we = 1; klo_wdata = 1;
        sb.push_back(mk(0, 0, 1, 1, 32'h4000));
        cycle();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid pre got %h exp %h", obs, e);
        end
        #3 rst_n = 0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 32'h0));
        obs = {sc0_success, sc1_success, llbit_o, klo_o, resv_addr_o};
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_mid async got %h exp %h", obs, e);
        end
        #2 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

`ifdef LLSC_TIMEOUT_EN
    task automatic test_timeout();
        for (int j = 0; j < 11; j++) begin
            if (j == 0) s0(MEM_LL, 32'hE000);
            sb.push_back(mk(0, 0, (j + 1 <= 8), 0, 32'hE000));
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout c%0d got %h exp %h", j + 1, obs, e);
            end
        end
        for (int j = 0; j < 16; j++) begin
            if (j == 0 || j == 5) s0(MEM_LL, 32'hE000);
            sb.push_back(mk(0, 0, (j + 1 <= 13), 0, 32'hE000));
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout_rearm c%0d got %h exp %h", j + 1, obs, e);
            end
        end
    endtask
`else
    task automatic test_timeout();
        for (int j = 0; j < 22; j++) begin
            if (j == 0) s0(MEM_LL, 32'hE000);
            if (j == 21) wcllb = 1;
            sb.push_back(mk(0, 0, (j < 21), 0, 32'hE000));
            cycle();
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL persist c%0d got %h exp %h", j + 1, obs, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ll_sc();
        test_snoop();
        test_dual_slot();
        test_flush_ertn();
        test_reset_mid();
        test_timeout();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover got %0d exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
